key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
Event scheduler between the per-key debouncers and the timer control FSM. Takes NUM_KEYS debounced, active-high key levels and classifies each key's activity into press, long-press, auto-repeat and release events. Serialises events from all keys onto one valid/ready event stream using round-robin arbitration. Owns a shared millisecond prescaler, so no per-key millisecond timers are needed.

Parameters:
NUM_KEYS, 4, number of debounced key inputs (>=2)
TICK_DIV, 50000, clk cycles per ms tick (1 ms at 50 MHz)
LONG_MS, 1000, ticks from press to LONG event (>=2)
REPEAT_MS, 200, ticks between REPEAT events (>=2)
CNT_W, 12, hold counter width; must hold max(LONG_MS, REPEAT_MS)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_level  in  NUM_KEYS  debounced levels, 1 = pressed, synchronous to clk
ev_valid  out  1  event available
ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
ev_key  out  $clog2(NUM_KEYS)  key index of event
ev_type  out  2  0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE
overflow  out  1  sticky: a pending event was overwritten
clear_ovf  in  1  clears overflow

Behaviour:
- Clocking and reset: single clk domain. Async active-low rst_n; released synchronously externally.
- Reset values: ev_valid=0, ev_key=0, ev_type=0, overflow=0. Also prescaler=0, key_prev=0, all key FSMs IDLE, all pend=0, rr pointer=NUM_KEYS-1.
- A key already high when reset is released produces a PRESS.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when count==TICK_DIV-1.
- Edge detection: key_prev registers key_level. rise=level&~prev; fall=~level&prev.
- Per-key FSM:
  - IDLE: on rise, emit PRESS, hold=0, go DOWN.
  - DOWN: on tick, hold++. On the tick where hold==LONG_MS-1, emit LONG, hold=0, go HELD.
  - HELD: on tick, hold++. On hold==REPEAT_MS-1, emit REPEAT and hold=0 (repeat build only).
  - Any non-IDLE state: fall emits RELEASE and goes to IDLE. Fall beats tick in the same cycle.
- Pending slot, one per key (pend flag + type), set at the clk edge after the event.
  - New event while pend=1 and not granted that cycle: newest type overwrites; overflow<=1.
  - Grant and new event for the same key in the same cycle: new event is stored, no overflow.
- Output register: loads when ev_valid==0 or (ev_valid & ev_ready).
  - Selects the first pending key searching upward from rr+1 (wrapping).
  - Loads ev_key/ev_type, clears that key's pend, rr<=granted key.
  - If none is pending, ev_valid<=0.
- Handshake: while ev_valid & ~ev_ready, ev_key/ev_type are held stable. Back-to-back transfers every cycle are allowed.
- Latency: level change in cycle t (edge seen at t+1 capture), pend set at t+1, ev_valid at t+2 when output free and no competing pend.
- clear_ovf clears overflow. A set in the same cycle wins.
- Hold counter saturates, never wraps (guards misconfiguration).

Optional Feature:
KEY_REPEAT_EN
- Defined: HELD emits REPEAT every REPEAT_MS ticks as above.
- Undefined: HELD idles until release, hold counter frozen, ev_type=2 never produced, REPEAT_MS ignored.

Decomposition:
- Package key_event_pkg: ev_type_t enum (EV_PRESS, EV_LONG, EV_REPEAT, EV_RELEASE), key_state_t enum (IDLE, DOWN, HELD).
- Sub-module key_fsm: one per key via generate. Contains edge detect, state, hold counter and pend slot. Inputs are level, tick and grant; outputs are pend and pend_type.
- Top level: prescaler, round-robin arbiter, output register, overflow.

Test Plan:
1. TICK_DIV=4, LONG_MS=5; key0 high 3 ticks then low, ev_ready=1 -> PRESS(0) 2 clk after rise, then RELEASE(0); no LONG.
2. KEY_REPEAT_EN, LONG_MS=5, REPEAT_MS=3; key1 high 13 ticks -> PRESS, LONG at tick 5, REPEAT at ticks 8 and 11, RELEASE; overflow=0.
3. ev_ready=1; key0 and key2 rise same cycle -> PRESS(0) then PRESS(2) on consecutive cycles. Then keys 1 and 3 rise together -> PRESS(3) then PRESS(1).
4. ev_ready=0; key0 press, release, press -> output holds PRESS(0) stable, overflow=1. Raise ev_ready -> PRESS(0) then PRESS(0). Pulse clear_ovf -> overflow=0.
5. rst_n low while key2 in HELD -> ev_valid=0, overflow=0 immediately. Release rst_n with key2 high -> PRESS(2).
6. Without KEY_REPEAT_EN; key3 held 20 ticks, LONG_MS=5 -> PRESS, LONG, RELEASE only.

Source files
------------

// File: rtl/key_event_pkg.sv
// key_event_pkg: event and per-key state types shared by key_event_ctrl and key_fsm.
package key_event_pkg;
  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_LONG    = 2'd1,
    EV_REPEAT  = 2'd2,
    EV_RELEASE = 2'd3
  } ev_type_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } key_state_t;
endpackage

// File: rtl/key_fsm.sv
// key_fsm: per-key edge detect, press/long/repeat/release classifier and one-deep pending slot.
// REPEAT events from HELD exist only when KEY_REPEAT_EN is defined; otherwise HELD waits for release.
module key_fsm
  import key_event_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 12
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     level,
  input  logic     tick,
  input  logic     grant,
  output logic     pend,
  output ev_type_t pend_type,
  output logic     ovf
);
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  key_state_t state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
  logic prev_q, pend_q, pend_d, ev, rise, fall;
  ev_type_t ptype_q, ptype_d, ev_t;

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;
  assign hold_inc = (&hold_q) ? hold_q : hold_q + 1'b1;

  // Release is checked before tick so a fall always wins over a same-cycle tick.
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    ev = 1'b0;
    ev_t = EV_PRESS;
    if (state_q == IDLE) begin
      if (rise) begin
        ev = 1'b1;
        hold_d = '0;
        state_d = DOWN;
      end
    end else if (fall) begin
      ev = 1'b1;
      ev_t = EV_RELEASE;
      state_d = IDLE;
    end else if (tick && state_q == DOWN) begin
      if (hold_q == CNT_W'(LONG_MS - 1)) begin
        ev = 1'b1;
        ev_t = EV_LONG;
        hold_d = '0;
        state_d = HELD;
      end else hold_d = hold_inc;
    end else if (tick && REP_EN) begin
      if (hold_q == CNT_W'(REPEAT_MS - 1)) begin
        ev = 1'b1;
        ev_t = EV_REPEAT;
        hold_d = '0;
      end else hold_d = hold_inc;
    end
    pend_d = ev | (pend_q & ~grant);
    ptype_d = ev ? ev_t : ptype_q;
  end

  assign ovf = ev & pend_q & ~grant;
  assign pend = pend_q;
  assign pend_type = ptype_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      ptype_q <= EV_PRESS;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      prev_q <= level;
      pend_q <= pend_d;
      ptype_q <= ptype_d;
    end
  end
endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: shared ms prescaler, per-key event FSMs and a round-robin valid/ready event stream.
// Define KEY_REPEAT_EN to enable auto-repeat events while a key stays held.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS  = 4,
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         key_level,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [$clog2(NUM_KEYS)-1:0] ev_key,
  output logic [1:0]                  ev_type,
  output logic                        overflow,
  input  logic                        clear_ovf
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;
  logic tick, load, found;
  logic [NUM_KEYS-1:0] pend, ovf, grant;
  ev_type_t pend_type [NUM_KEYS];
  logic [KW-1:0] rr_q, rr_d, sel, idx;
  logic ev_valid_q, ev_valid_d, overflow_q, overflow_d;
  logic [KW-1:0] ev_key_q, ev_key_d;
  ev_type_t ev_type_q, ev_type_d;

  assign tick = cnt_q == PW'(TICK_DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign load = ~ev_valid_q | ev_ready;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_fsm #(
      .LONG_MS(LONG_MS),
      .REPEAT_MS(REPEAT_MS),
      .CNT_W(CNT_W)
    ) u_fsm (
      .clk(clk),
      .rst_n(rst_n),
      .level(key_level[k]),
      .tick(tick),
      .grant(grant[k]),
      .pend(pend[k]),
      .pend_type(pend_type[k]),
      .ovf(ovf[k])
    );
  end

  // Search starts just after the last granted key so every key gets a turn.
  always_comb begin
    found = 1'b0;
    sel = rr_q;
    idx = rr_q;
    for (int i = 1; i <= NUM_KEYS; i++) begin
      idx = KW'((int'(rr_q) + i) % NUM_KEYS);
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end

  assign grant = (load && found) ? NUM_KEYS'(1) << sel : '0;

  always_comb begin
    ev_valid_d = load ? found : ev_valid_q;
    ev_key_d = (load && found) ? sel : ev_key_q;
    ev_type_d = (load && found) ? pend_type[sel] : ev_type_q;
    rr_d = (load && found) ? sel : rr_q;
    overflow_d = (|ovf) ? 1'b1 : clear_ovf ? 1'b0 : overflow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rr_q <= KW'(NUM_KEYS - 1);
      ev_valid_q <= 1'b0;
      ev_key_q <= '0;
      ev_type_q <= EV_PRESS;
      overflow_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      ev_valid_q <= ev_valid_d;
      ev_key_q <= ev_key_d;
      ev_type_q <= ev_type_d;
      overflow_q <= overflow_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_key = ev_key_q;
  assign ev_type = ev_type_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed scenarios plus random key activity against a tick-counting reference model.
module tb_key_event_ctrl;
  import key_event_pkg::*;
  localparam int NK = 4, TD = 4, LM = 5, RM = 3;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 0, rst_n = 0, ev_ready = 1, clear_ovf = 0;
  logic [NK-1:0] key_level = '0;
  logic ev_valid, overflow;
  logic [1:0] ev_key, ev_type;
  int checks = 0, failures = 0;
  bit m_valid, m_ovf;
  bit [1:0] m_key, m_type;
  bit [NK-1:0] m_prev, m_pend;
  bit [1:0] m_ptype [NK];
  int m_n [NK];
  int m_cnt, m_rr;
  logic [3:0] obs[$], want[$];
  bit bad;

  always #5 clk = ~clk;

  key_event_ctrl #(.NUM_KEYS(NK), .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(RM), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .key_level(key_level), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_key(ev_key), .ev_type(ev_type), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  task automatic model_reset();
    m_valid = 0; m_key = 0; m_type = 0; m_ovf = 0; m_prev = 0; m_pend = 0;
    m_cnt = 0; m_rr = NK - 1;
    for (int k = 0; k < NK; k++) begin m_ptype[k] = 0; m_n[k] = 0; end
  endtask

  // Events come from the number of ms ticks seen since the press, not from a restarting counter.
  task automatic model_update();
    bit tick, load, any;
    int g, e;
    bit [1:0] gt;
    tick = m_cnt == TD - 1;
    load = !m_valid || ev_ready;
    g = -1; gt = 0; any = 0;
    m_cnt = tick ? 0 : m_cnt + 1;
    if (load) for (int i = 1; i <= NK; i++) if (g < 0 && m_pend[(m_rr + i) % NK]) g = (m_rr + i) % NK;
    if (g >= 0) gt = m_ptype[g];
    for (int k = 0; k < NK; k++) begin
      e = -1;
      if (key_level[k] && !m_prev[k]) begin e = 0; m_n[k] = 0; end
      else if (!key_level[k] && m_prev[k]) e = 3;
      else if (m_prev[k] && tick) begin
        m_n[k]++;
        if (m_n[k] == LM) e = 1;
        else if (REP && m_n[k] > LM && (m_n[k] - LM) % RM == 0) e = 2;
      end
      if (e >= 0) begin
        if (m_pend[k] && g != k) any = 1;
        m_pend[k] = 1;
        m_ptype[k] = 2'(e);
      end else if (g == k) m_pend[k] = 0;
    end
    if (load) begin
      m_valid = g >= 0;
      if (g >= 0) begin m_key = 2'(g); m_type = gt; m_rr = g; end
    end
    m_ovf = any ? 1'b1 : clear_ovf ? 1'b0 : m_ovf;
    m_prev = key_level;
  endtask

  task automatic step();
    if (rst_n && ev_valid && ev_ready) obs.push_back({ev_key, ev_type});
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; key_level = '0; ev_ready = 1; clear_ovf = 0;
    model_reset();
    step(); step();
    checks++;
    if ({ev_valid, ev_key, ev_type, overflow} !== 6'b0) begin
      failures++; $display("FAIL reset_values got %b want 000000", {ev_valid, ev_key, ev_type, overflow});
    end
    rst_n = 1;
    repeat (4) begin
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL reset_idle @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
  endtask

  task automatic test_single_press();
    obs.delete();
    key_level[0] = 1;
    step(); step();
    checks++;
    if ({ev_valid, ev_key, ev_type} !== {1'b1, 2'd0, EV_PRESS}) begin
      failures++; $display("FAIL press_latency got %b want 10000", {ev_valid, ev_key, ev_type});
    end
    for (int c = 0; c < 28; c++) begin
      if (c == 10) key_level[0] = 0;
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL single_press @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
    want = '{4'h0, 4'h3};
    bad = obs.size() != want.size();
    foreach (want[i]) if (i < obs.size() && obs[i] !== want[i]) bad = 1;
    checks++;
    if (bad) begin failures++; $display("FAIL single_seq got %p want %p", obs, want); end
  endtask

  task automatic test_long_repeat();
    obs.delete();
    key_level[1] = 1;
    for (int c = 0; c < 60; c++) begin
      if (c == 50) key_level[1] = 0;
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL long_repeat @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
    if (REP) want = '{4'h4, 4'h5, 4'h6, 4'h6, 4'h7};
    else want = '{4'h4, 4'h5, 4'h7};
    bad = obs.size() != want.size();
    foreach (want[i]) if (i < obs.size() && obs[i] !== want[i]) bad = 1;
    checks++;
    if (bad) begin failures++; $display("FAIL long_repeat_seq got %p want %p", obs, want); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL long_repeat_ovf got %b want 0", overflow); end
  endtask

  task automatic test_simultaneous();
    rst_n = 0; model_reset(); step(); rst_n = 1;
    key_level = 4'b0101;
    step(); step();
    checks++;
    if ({ev_valid, ev_key, ev_type} !== {1'b1, 2'd0, EV_PRESS}) begin
      failures++; $display("FAIL rr_first got %b want 10000", {ev_valid, ev_key, ev_type});
    end
    step();
    checks++;
    if ({ev_valid, ev_key, ev_type} !== {1'b1, 2'd2, EV_PRESS}) begin
      failures++; $display("FAIL rr_second got %b want 11000", {ev_valid, ev_key, ev_type});
    end
    key_level = 4'b1111;
    step(); step();
    checks++;
    if ({ev_valid, ev_key, ev_type} !== {1'b1, 2'd3, EV_PRESS}) begin
      failures++; $display("FAIL rr_third got %b want 11100", {ev_valid, ev_key, ev_type});
    end
    step();
    checks++;
    if ({ev_valid, ev_key, ev_type} !== {1'b1, 2'd1, EV_PRESS}) begin
      failures++; $display("FAIL rr_fourth got %b want 10100", {ev_valid, ev_key, ev_type});
    end
    key_level = 4'b0000;
    repeat (10) begin
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL rr_release @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
  endtask

  task automatic test_overflow();
    obs.delete();
    ev_ready = 0;
    for (int c = 0; c < 9; c++) begin
      key_level[0] = (c < 3 || c >= 6);
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL ovf_stall @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
    checks++;
    if ({ev_valid, ev_key, ev_type, overflow} !== {1'b1, 2'd0, EV_PRESS, 1'b1}) begin
      failures++; $display("FAIL ovf_hold got %b want 100001", {ev_valid, ev_key, ev_type, overflow});
    end
    ev_ready = 1;
    step();
    checks++;
    if ({ev_valid, ev_key, ev_type} !== {1'b1, 2'd0, EV_PRESS}) begin
      failures++; $display("FAIL ovf_newest got %b want 10000", {ev_valid, ev_key, ev_type});
    end
    step();
    want = '{4'h0, 4'h0};
    bad = obs.size() != want.size();
    foreach (want[i]) if (i < obs.size() && obs[i] !== want[i]) bad = 1;
    checks++;
    if (bad) begin failures++; $display("FAIL ovf_seq got %p want %p", obs, want); end
    clear_ovf = 1; step(); clear_ovf = 0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", overflow); end
    key_level[0] = 0;
    repeat (4) step();
  endtask

  task automatic test_reset_held();
    ev_ready = 0;
    for (int c = 0; c < 61; c++) begin
      key_level[2] = c != 30;
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL held_stall @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
    checks++;
    if ({ev_valid, overflow} !== 2'b11) begin failures++; $display("FAIL held_pre_reset got %b want 11", {ev_valid, overflow}); end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if ({ev_valid, overflow} !== 2'b00) begin failures++; $display("FAIL async_reset got %b want 00", {ev_valid, overflow}); end
    step();
    rst_n = 1; ev_ready = 1;
    step(); step();
    checks++;
    if ({ev_valid, ev_key, ev_type} !== {1'b1, 2'd2, EV_PRESS}) begin
      failures++; $display("FAIL press_after_reset got %b want 11000", {ev_valid, ev_key, ev_type});
    end
    key_level[2] = 0;
    repeat (6) begin
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL reset_drain @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
  endtask

  task automatic test_no_repeat();
    obs.delete();
    key_level[3] = 1;
    for (int c = 0; c < 84; c++) begin
      if (c == 74) key_level[3] = 0;
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL long_hold @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
    if (REP) want = '{4'hC, 4'hD, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF};
    else want = '{4'hC, 4'hD, 4'hF};
    bad = obs.size() != want.size();
    foreach (want[i]) if (i < obs.size() && obs[i] !== want[i]) bad = 1;
    checks++;
    if (bad) begin failures++; $display("FAIL long_hold_seq got %p want %p", obs, want); end
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin k = $urandom_range(0, NK - 1); key_level[k] = ~key_level[k]; end
      ev_ready = $urandom_range(0, 3) != 0;
      clear_ovf = $urandom_range(0, 31) == 0;
      step();
      checks++;
      if ({ev_valid, ev_key, ev_type, overflow} !== {m_valid, m_key, m_type, m_ovf}) begin
        failures++; $display("FAIL random @%0t got %b want %b", $time, {ev_valid, ev_key, ev_type, overflow}, {m_valid, m_key, m_type, m_ovf});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_long_repeat();
    test_simultaneous();
    test_overflow();
    test_reset_held();
    test_no_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
